// File: rtl/spi_pkg.sv
// Shared definitions for the SPI write controller: frame geometry, FSM states,
// register map of the SPI register peripheral, and the frame packing helper.
package spi_pkg;

  localparam int unsigned SPI_FRAME_BITS = 16;
  localparam int unsigned SPI_ADDR_W     = 7;
  localparam int unsigned SPI_DATA_W     = 8;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } spi_state_e;

  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_REG_OUT_7_0  = 7'h00;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_REG_OUT_15_8 = 7'h01;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_REG_PWM_7_0  = 7'h02;
  localparam logic [SPI_ADDR_W-1:0] ADDR_EN_REG_PWM_15_8 = 7'h03;
  localparam logic [SPI_ADDR_W-1:0] ADDR_PWM_DUTY_CYCLE  = 7'h04;

  // Frame layout: {rw, addr, data}, transmitted MSB first.
  function automatic logic [SPI_FRAME_BITS-1:0] make_frame(
    input logic                  rw,
    input logic [SPI_ADDR_W-1:0] addr,
    input logic [SPI_DATA_W-1:0] data
  );
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_controller_if.sv
// Request interface of the SPI controller. With SPI_CTRL_READ_EN defined it
// also carries the read/write select and the read-back data.
interface spi_controller_if;
  import spi_pkg::*;

  logic                  req_valid;
  logic                  req_ready;
  logic [SPI_ADDR_W-1:0] req_addr;
  logic [SPI_DATA_W-1:0] req_data;
`ifdef SPI_CTRL_READ_EN
  logic                  req_rw;
  logic [SPI_DATA_W-1:0] rdata;
`endif

  modport master (
`ifdef SPI_CTRL_READ_EN
    output req_rw,
    input  rdata,
`endif
    output req_valid,
    output req_addr,
    output req_data,
    input  req_ready
  );

  modport slave (
`ifdef SPI_CTRL_READ_EN
    input  req_rw,
    output rdata,
`endif
    input  req_valid,
    input  req_addr,
    input  req_data,
    output req_ready
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SCLK generator: half-period divider with enable. half_c marks the last cycle
// of every half-period; rise_c/fall_c mark the cycle before SCLK toggles and
// only fire while run is high, so the divider can also time idle phases.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic run,
  output logic sclk,
  output logic half_c,
  output logic rise_c,
  output logic fall_c
);

  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  assign half_c = en && (cnt == DIV_LAST);
  assign rise_c = half_c && run && !sclk;
  assign fall_c = half_c && run && sclk;

  // Divider counter and SCLK level; both parked at 0 while disabled.
  always_ff @(posedge clk) begin
    if (!rst_n || !en) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else begin
      cnt <= half_c ? '0 : cnt + DIV_W'(1);
      if (rise_c) begin
        sclk <= 1'b1;
      end else if (fall_c) begin
        sclk <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_controller.sv
// SPI initiator: one register write per valid/ready handshake, sent as a
// 16-bit mode-0 frame MSB first. Optional read support via SPI_CTRL_READ_EN.
module spi_controller
  import spi_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned GAP_HALVES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  spi_controller_if.slave  req,
`ifdef SPI_CTRL_READ_EN
  input  logic             CIPO,
`endif
  output logic             busy,
  output logic             done,
  output logic             nCS,
  output logic             SCLK,
  output logic             COPI
);

  localparam int unsigned GAP_W = $clog2(GAP_HALVES + 1);

  spi_state_e                state;
  logic [SPI_FRAME_BITS-1:0] shreg;
  logic [4:0]                bit_cnt;   // [4] is the terminal flag after 16 rises
  logic [GAP_W-1:0]          gap_cnt;
  logic [SPI_FRAME_BITS-1:0] frame;
  logic                      half_c;
  logic                      rise_c;
  logic                      fall_c;
`ifdef SPI_CTRL_READ_EN
  logic                      rw_q;
  logic [SPI_DATA_W-1:0]     rx;
`endif

`ifdef SPI_CTRL_READ_EN
  assign frame = make_frame(req.req_rw, req.req_addr, req.req_data);
`else
  assign frame = make_frame(1'b1, req.req_addr, req.req_data);
`endif

  spi_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .en     (state != IDLE),
    .run    (state == SHIFT),
    .sclk   (SCLK),
    .half_c (half_c),
    .rise_c (rise_c),
    .fall_c (fall_c)
  );

  // Controller FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      req.req_ready <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      nCS           <= 1'b1;
      COPI          <= 1'b0;
      shreg         <= '0;
      bit_cnt       <= '0;
      gap_cnt       <= '0;
`ifdef SPI_CTRL_READ_EN
      rw_q          <= 1'b1;
      rx            <= '0;
      req.rdata     <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req.req_valid && req.req_ready) begin
            shreg         <= frame;
            COPI          <= frame[SPI_FRAME_BITS-1];
            nCS           <= 1'b0;
            busy          <= 1'b1;
            req.req_ready <= 1'b0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
`ifdef SPI_CTRL_READ_EN
            rw_q          <= req.req_rw;
`endif
            state         <= SHIFT;
          end
        end
        SHIFT: begin
          if (rise_c) begin
            bit_cnt <= bit_cnt + 5'd1;
`ifdef SPI_CTRL_READ_EN
            if (bit_cnt[3] && !rw_q) begin
              rx <= {rx[SPI_DATA_W-2:0], CIPO};
            end
`endif
          end
          if (fall_c) begin
            if (bit_cnt[4]) begin
              state <= HOLD;
            end
            shreg <= {shreg[SPI_FRAME_BITS-2:0], 1'b0};
            COPI  <= shreg[SPI_FRAME_BITS-2];
          end
        end
        HOLD: begin
          if (half_c) begin
            nCS   <= 1'b1;
            COPI  <= 1'b0;
            state <= GAP;
          end
        end
        GAP: begin
          if (half_c) begin
            if (gap_cnt == GAP_W'(GAP_HALVES - 1)) begin
              state         <= IDLE;
              done          <= 1'b1;
              busy          <= 1'b0;
              req.req_ready <= 1'b1;
`ifdef SPI_CTRL_READ_EN
              if (!rw_q) begin
                req.rdata <= rx;
              end
`endif
            end else begin
              gap_cnt <= gap_cnt + GAP_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller at CLK_DIV=4 and CLK_DIV=2, with a
// behavioural SPI register receiver decoding the COPI stream.
module tb_spi_controller;
  import spi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n4, rst_n2;
  logic busy4, done4, ncs4, sclk4, copi4;
  logic busy2, done2, ncs2, sclk2, copi2;
`ifdef SPI_CTRL_READ_EN
  logic cipo4, cipo2;
  logic [7:0] rd_val4 = 8'h3C;
`endif

  int errors = 0;
  int checks = 0;

  spi_controller_if ifc4();
  spi_controller_if ifc2();

  spi_controller #(.CLK_DIV(4), .GAP_HALVES(2)) u4 (
    .clk(clk), .rst_n(rst_n4), .req(ifc4),
`ifdef SPI_CTRL_READ_EN
    .CIPO(cipo4),
`endif
    .busy(busy4), .done(done4), .nCS(ncs4), .SCLK(sclk4), .COPI(copi4)
  );

  spi_controller #(.CLK_DIV(2), .GAP_HALVES(2)) u2 (
    .clk(clk), .rst_n(rst_n2), .req(ifc2),
`ifdef SPI_CTRL_READ_EN
    .CIPO(cipo2),
`endif
    .busy(busy2), .done(done2), .nCS(ncs2), .SCLK(sclk2), .COPI(copi2)
  );

  // Receiver model: shift COPI on SCLK rise, commit complete frames on nCS rise.
  int          mon_bits4 = 0;
  int          mon_bits2 = 0;
  logic [15:0] mon_sr4, mon_sr2;
  logic [15:0] frames4[$];
  logic [15:0] frames2[$];
  logic [7:0]  regs4[0:4];
  int          idx4;

  always @(posedge sclk4) if (ncs4 === 1'b0) begin mon_sr4 = {mon_sr4[14:0], copi4}; mon_bits4++; end
  always @(posedge sclk2) if (ncs2 === 1'b0) begin mon_sr2 = {mon_sr2[14:0], copi2}; mon_bits2++; end

  always @(posedge ncs4) begin
    if (mon_bits4 == 16) begin
      frames4.push_back(mon_sr4);
      idx4 = int'(mon_sr4[14:8]);
      if (mon_sr4[15] && idx4 <= 4) regs4[idx4] = mon_sr4[7:0];
    end
    mon_bits4 = 0;
  end

  always @(posedge ncs2) begin
    if (mon_bits2 == 16) frames2.push_back(mon_sr2);
    mon_bits2 = 0;
  end

`ifdef SPI_CTRL_READ_EN
  // Peripheral read model: presents rd_val4 MSB first during bits 7:0.
  always_comb begin
    cipo4 = 1'b0;
    if (mon_bits4 >= 8 && mon_bits4 < 16) cipo4 = rd_val4[3'(15 - mon_bits4)];
  end
  assign cipo2 = 1'b0;
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    rst_n4 = 1'b0; rst_n2 = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (ifc4.req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ifc4.req_ready); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy4); end
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done4); end
    checks++; if (ncs4 !== 1'b1) begin errors++; $display("FAIL reset_ncs got=%b exp=1", ncs4); end
    checks++; if (sclk4 !== 1'b0) begin errors++; $display("FAIL reset_sclk got=%b exp=0", sclk4); end
    checks++; if (copi4 !== 1'b0) begin errors++; $display("FAIL reset_copi got=%b exp=0", copi4); end
    checks++; if (ncs2 !== 1'b1) begin errors++; $display("FAIL reset_ncs_div2 got=%b exp=1", ncs2); end
`ifdef SPI_CTRL_READ_EN
    checks++; if (ifc4.rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got=%h exp=00", ifc4.rdata); end
`endif
    rst_n4 = 1'b1; rst_n2 = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    int low, gap, budget, nf;
    nf = frames4.size();
    checks++; if (ifc4.req_ready !== 1'b1) begin errors++; $display("FAIL write_ready_idle got=%b exp=1", ifc4.req_ready); end
    ifc4.req_addr = ADDR_PWM_DUTY_CYCLE; ifc4.req_data = 8'h80; ifc4.req_valid = 1'b1;
    @(negedge clk);
    ifc4.req_valid = 1'b0;
    checks++; if (ncs4 !== 1'b0) begin errors++; $display("FAIL write_ncs_first got=%b exp=0", ncs4); end
    checks++; if (copi4 !== 1'b1) begin errors++; $display("FAIL write_copi_bit15 got=%b exp=1", copi4); end
    checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL write_busy got=%b exp=1", busy4); end
    checks++; if (ifc4.req_ready !== 1'b0) begin errors++; $display("FAIL write_ready_busy got=%b exp=0", ifc4.req_ready); end
    low = 0; budget = 0;
    while (ncs4 === 1'b0 && budget < 1000) begin low++; @(negedge clk); budget++; end
    checks++; if (low != 132) begin errors++; $display("FAIL write_ncs_low_cycles got=%0d exp=132", low); end
    gap = 0;
    while (ncs4 === 1'b1 && done4 !== 1'b1 && budget < 2000) begin gap++; @(negedge clk); budget++; end
    checks++; if (gap != 8) begin errors++; $display("FAIL write_gap_cycles got=%0d exp=8", gap); end
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL write_done got=%b exp=1", done4); end
    checks++; if (ifc4.req_ready !== 1'b1) begin errors++; $display("FAIL write_ready_done got=%b exp=1", ifc4.req_ready); end
    @(negedge clk);
    checks++; if (done4 !== 1'b0) begin errors++; $display("FAIL write_done_width got=%b exp=0", done4); end
    checks++; if (frames4.size() != nf + 1) begin errors++; $display("FAIL write_frame_count got=%0d exp=%0d", frames4.size(), nf + 1); end
    checks++; if (frames4[$] !== 16'h8480) begin errors++; $display("FAIL write_frame got=%h exp=8480", frames4[$]); end
    checks++; if (regs4[4] !== 8'h80) begin errors++; $display("FAIL write_pwm_duty got=%h exp=80", regs4[4]); end
  endtask

  task automatic test_back_to_back();
    int budget, hi, n;
    bit saw;
    ifc4.req_addr = ADDR_EN_REG_OUT_7_0; ifc4.req_data = 8'hFF; ifc4.req_valid = 1'b1;
    @(negedge clk);
    checks++; if (ncs4 !== 1'b0) begin errors++; $display("FAIL b2b_first_start got=%b exp=0", ncs4); end
    ifc4.req_addr = ADDR_EN_REG_PWM_7_0; ifc4.req_data = 8'h0F;
    budget = 0;
    while (ncs4 === 1'b0 && budget < 1000) begin @(negedge clk); budget++; end
    hi = 0; saw = 1'b0;
    while (ncs4 === 1'b1 && budget < 2000) begin
      if (done4 === 1'b1 && ifc4.req_ready === 1'b1) saw = 1'b1;
      hi++; @(negedge clk); budget++;
    end
    ifc4.req_valid = 1'b0;
    checks++; if (saw !== 1'b1) begin errors++; $display("FAIL b2b_done_ready got=%b exp=1", saw); end
    checks++; if (hi != 9) begin errors++; $display("FAIL b2b_ncs_high_cycles got=%0d exp=9", hi); end
    while (done4 !== 1'b1 && budget < 3000) begin @(negedge clk); budget++; end
    checks++; if (done4 !== 1'b1) begin errors++; $display("FAIL b2b_second_done got=%b exp=1", done4); end
    @(negedge clk);
    n = frames4.size();
    checks++;
    if (n < 2) begin
      errors++; $display("FAIL b2b_frames got=%0d frames exp>=2", n);
    end else if (frames4[n-2] !== 16'h80FF || frames4[n-1] !== 16'h820F) begin
      errors++; $display("FAIL b2b_frames got=%h,%h exp=80ff,820f", frames4[n-2], frames4[n-1]);
    end
    checks++; if (regs4[0] !== 8'hFF) begin errors++; $display("FAIL b2b_en_out_7_0 got=%h exp=ff", regs4[0]); end
    checks++; if (regs4[2] !== 8'h0F) begin errors++; $display("FAIL b2b_en_pwm_7_0 got=%h exp=0f", regs4[2]); end
  endtask

  task automatic test_busy_ignore();
    int nf, dones;
    logic [7:0] r1;
    nf = frames4.size(); r1 = regs4[1]; dones = 0;
    ifc4.req_addr = ADDR_PWM_DUTY_CYCLE; ifc4.req_data = 8'h5A; ifc4.req_valid = 1'b1;
    @(negedge clk);
    ifc4.req_valid = 1'b0;
    repeat (20) @(negedge clk);
    ifc4.req_addr = ADDR_EN_REG_OUT_15_8; ifc4.req_data = 8'h77; ifc4.req_valid = 1'b1;
    checks++; if (ifc4.req_ready !== 1'b0) begin errors++; $display("FAIL ignore_ready got=%b exp=0", ifc4.req_ready); end
    @(negedge clk);
    ifc4.req_valid = 1'b0;
    repeat (400) begin @(negedge clk); if (done4 === 1'b1) dones++; end
    checks++; if (dones != 1) begin errors++; $display("FAIL ignore_done_count got=%0d exp=1", dones); end
    checks++; if (frames4.size() != nf + 1) begin errors++; $display("FAIL ignore_frame_count got=%0d exp=%0d", frames4.size(), nf + 1); end
    checks++; if (frames4[$] !== 16'h845A) begin errors++; $display("FAIL ignore_frame got=%h exp=845a", frames4[$]); end
    checks++; if (regs4[1] !== r1) begin errors++; $display("FAIL ignore_en_out_15_8 got=%h exp=%h", regs4[1], r1); end
  endtask

  task automatic test_reset_mid();
    int nf, rises, budget, dones;
    logic prev;
    logic [7:0] r3;
    nf = frames4.size(); r3 = regs4[3]; dones = 0;
    ifc4.req_addr = ADDR_EN_REG_PWM_15_8; ifc4.req_data = 8'h55; ifc4.req_valid = 1'b1;
    @(negedge clk);
    ifc4.req_valid = 1'b0;
    rises = 0; budget = 0; prev = sclk4;
    while (rises < 5 && budget < 500) begin
      @(negedge clk); budget++;
      if (sclk4 === 1'b1 && prev === 1'b0) rises++;
      prev = sclk4;
    end
    checks++; if (rises != 5) begin errors++; $display("FAIL midrst_rises got=%0d exp=5", rises); end
    rst_n4 = 1'b0;
    @(negedge clk);
    rst_n4 = 1'b1;
    checks++; if (ncs4 !== 1'b1) begin errors++; $display("FAIL midrst_ncs got=%b exp=1", ncs4); end
    checks++; if (sclk4 !== 1'b0) begin errors++; $display("FAIL midrst_sclk got=%b exp=0", sclk4); end
    checks++; if (copi4 !== 1'b0) begin errors++; $display("FAIL midrst_copi got=%b exp=0", copi4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy4); end
    checks++; if (ifc4.req_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready got=%b exp=1", ifc4.req_ready); end
    if (done4 === 1'b1) dones++;
    repeat (300) begin @(negedge clk); if (done4 === 1'b1) dones++; end
    checks++; if (dones != 0) begin errors++; $display("FAIL midrst_done_count got=%0d exp=0", dones); end
    checks++; if (frames4.size() != nf) begin errors++; $display("FAIL midrst_frame_count got=%0d exp=%0d", frames4.size(), nf); end
    checks++; if (regs4[3] !== r3) begin errors++; $display("FAIL midrst_en_pwm_15_8 got=%h exp=%h", regs4[3], r3); end
  endtask

  task automatic test_clk_div2();
    int low, gap, budget, t, nr, r1, r2;
    logic prev;
    ifc2.req_addr = ADDR_EN_REG_PWM_15_8; ifc2.req_data = 8'hA5; ifc2.req_valid = 1'b1;
    @(negedge clk);
    ifc2.req_valid = 1'b0;
    checks++; if (ncs2 !== 1'b0) begin errors++; $display("FAIL div2_ncs_first got=%b exp=0", ncs2); end
    low = 0; budget = 0; t = 0; nr = 0; r1 = 0; r2 = 0; prev = sclk2;
    while (ncs2 === 1'b0 && budget < 500) begin
      low++; @(negedge clk); budget++; t++;
      if (sclk2 === 1'b1 && prev === 1'b0) begin
        if (nr == 0) r1 = t; else if (nr == 1) r2 = t;
        nr++;
      end
      prev = sclk2;
    end
    checks++; if (low != 66) begin errors++; $display("FAIL div2_ncs_low_cycles got=%0d exp=66", low); end
    checks++; if (r2 - r1 != 4) begin errors++; $display("FAIL div2_sclk_period got=%0d exp=4", r2 - r1); end
    checks++; if (nr != 16) begin errors++; $display("FAIL div2_sclk_rises got=%0d exp=16", nr); end
    gap = 0;
    while (ncs2 === 1'b1 && done2 !== 1'b1 && budget < 1000) begin gap++; @(negedge clk); budget++; end
    checks++; if (gap != 4) begin errors++; $display("FAIL div2_gap_cycles got=%0d exp=4", gap); end
    checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL div2_done got=%b exp=1", done2); end
    @(negedge clk);
    checks++; if (frames2[$] !== 16'h83A5) begin errors++; $display("FAIL div2_frame got=%h exp=83a5", frames2[$]); end
  endtask

`ifdef SPI_CTRL_READ_EN
  task automatic test_read();
    int budget;
    logic [7:0] r4;
    r4 = regs4[4];
    ifc4.req_rw = 1'b0; ifc4.req_addr = ADDR_PWM_DUTY_CYCLE; ifc4.req_data = 8'h00; ifc4.req_valid = 1'b1;
    @(negedge clk);
    ifc4.req_valid = 1'b0; ifc4.req_rw = 1'b1;
    budget = 0;
    while (done4 !== 1'b1 && budget < 500) begin @(negedge clk); budget++; end
    checks++; if (ifc4.rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata got=%h exp=3c", ifc4.rdata); end
    checks++; if (frames4[$] !== 16'h0400) begin errors++; $display("FAIL read_frame got=%h exp=0400", frames4[$]); end
    checks++; if (regs4[4] !== r4) begin errors++; $display("FAIL read_no_write got=%h exp=%h", regs4[4], r4); end
    @(negedge clk);
    ifc4.req_addr = ADDR_EN_REG_OUT_7_0; ifc4.req_data = 8'h11; ifc4.req_valid = 1'b1;
    @(negedge clk);
    ifc4.req_valid = 1'b0;
    budget = 0;
    while (done4 !== 1'b1 && budget < 500) begin @(negedge clk); budget++; end
    checks++; if (ifc4.rdata !== 8'h3C) begin errors++; $display("FAIL read_rdata_hold got=%h exp=3c", ifc4.rdata); end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 5; i++) regs4[i] = 8'h00;
    ifc4.req_valid = 1'b0; ifc4.req_addr = '0; ifc4.req_data = '0;
    ifc2.req_valid = 1'b0; ifc2.req_addr = '0; ifc2.req_data = '0;
`ifdef SPI_CTRL_READ_EN
    ifc4.req_rw = 1'b1; ifc2.req_rw = 1'b1;
`endif
    rst_n4 = 1'b0; rst_n2 = 1'b0;
    test_reset();
    test_single_write();
    test_back_to_back();
    test_busy_ignore();
    test_reset_mid();
    test_clk_div2();
`ifdef SPI_CTRL_READ_EN
    test_read();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
SPI initiator that drives the 3-wire write protocol (nCS, COPI, SCLK) consumed by the on-chip SPI register peripheral.
- Accepts one register write per valid/ready handshake and serialises it as a 16-bit mode-0 frame, MSB first.
- Used as the on-chip configuration master for the PWM enable/duty registers, and as the bench driver for the peripheral.

Parameters:
- CLK_DIV, 4: SCLK half-period in clk cycles. Legal range is >=2; >=4 is required when driving the in-design peripheral, whose inputs are synchronised.
- GAP_HALVES, 2: minimum nCS-high idle time between frames, in SCLK half-periods.

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- req_valid  input  1  request present
- req_ready  output  1  controller can accept a request
- req_addr  input  7  register address
- req_data  input  8  write data
- busy  output  1  frame in progress (SETUP through GAP)
- done  output  1  one-cycle pulse when a frame completes
- nCS  output  1  chip select, active low
- SCLK  output  1  serial clock, idle low
- COPI  output  1  serial data out

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- Reset values: req_ready=1, busy=0, done=0, nCS=1, SCLK=0, COPI=0, all counters 0.
- All outputs are registered.
- Frame format: bit15 = 1 (write), bits14:8 = req_addr, bits7:0 = req_data, sent MSB first.
- States:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch the frame and go to SHIFT.
  - SHIFT: 16 bits. Each bit holds SCLK low for CLK_DIV cycles, then SCLK high for CLK_DIV cycles. COPI changes only on the cycle SCLK falls, or on frame entry. The first low phase is the setup time.
  - HOLD: SCLK low, nCS low for CLK_DIV cycles after the 16th falling edge.
  - GAP: nCS=1, COPI=0 for GAP_HALVES*CLK_DIV cycles.
  - After GAP: return to IDLE.
- Timing from the handshake edge:
  - nCS=0 and COPI=bit15 on the next cycle.
  - nCS stays low for exactly 33*CLK_DIV cycles.
  - done=1 for one cycle on the cycle the FSM re-enters IDLE; req_ready=1 on that same cycle.
  - Back-to-back requests: a new request can be accepted on the done cycle.
- req_valid while busy: ignored; req_ready=0, no latching.
- Request data: req_addr/req_data are sampled only at the handshake, so later input changes do not affect the frame in flight.
- Reset mid-frame: the next cycle shows reset values; no done pulse. A partial frame of fewer than 16 bits must be discarded by the receiver on nCS rise.
- Bit counter: 4 bits plus a terminal flag; no wrap past 16.
- Divider counter: width clog2(CLK_DIV); rolls over at CLK_DIV-1.

Optional Feature:
SPI_CTRL_READ_EN
- Defined:
  - Adds input req_rw (1 = write, 0 = read), which drives bit15.
  - Adds input CIPO (1 bit) and output rdata (8 bits, reset 0).
  - During read frames, CIPO is sampled on each SCLK rising edge of bits 7:0 and shifted MSB first.
  - rdata updates on the done cycle and holds until the next read completes.
  - Write frames leave rdata unchanged.
- Undefined: req_rw, CIPO and rdata are absent, and bit15 is tied to 1.

Decomposition:
- Package spi_pkg:
  - SPI_FRAME_BITS=16, SPI_ADDR_W=7, SPI_DATA_W=8.
  - Controller state enum {IDLE, SHIFT, HOLD, GAP}.
  - Register address constants: 0x00 en_reg_out_7_0, 0x01 en_reg_out_15_8, 0x02 en_reg_pwm_7_0, 0x03 en_reg_pwm_15_8, 0x04 pwm_duty_cycle.
- Sub-module spi_clk_gen:
  - Half-period counter with enable.
  - Outputs one-cycle rise and fall strobes plus SCLK level.
  - Reused by any future SPI master.

Test Plan:
- CLK_DIV=4, write addr 0x04, data 0x80 -> COPI sampled at SCLK rises = 0x8480 MSB first; nCS low 132 cycles; done 1 cycle after a GAP of 8 cycles. Looped into the SPI register peripheral -> pwm_duty_cycle=0x80.
- req_valid held high, writes 0x00/0xFF then 0x02/0x0F -> second handshake on the first frame's done cycle; nCS high >=8 cycles between frames. Peripheral -> en_reg_out_7_0=0xFF, en_reg_pwm_7_0=0x0F.
- rst_n=0 for 1 cycle after the 5th SCLK rise -> next cycle nCS=1, SCLK=0, COPI=0, busy=0, no done. Peripheral registers unchanged.
- req_valid pulsed mid-frame with addr 0x01 -> req_ready=0, request ignored, in-flight frame bits unchanged, only one done.
- CLK_DIV=2, write 0x03/0xA5 -> SCLK period 4 cycles, nCS low 66 cycles, frame 0x83A5.
- With SPI_CTRL_READ_EN: read addr 0x04, CIPO model returns 0x3C -> frame bit15=0, rdata=0x3C on the done cycle.
